// File: rtl/word_splitter.sv
// Tokenizer: raw ASCII bytes in, upper-case word bytes out, each word closed by 8'd0.
// Latency 1 clock from input transfer to out_byte; no output back-pressure.
// in_ready drops for the single FLUSH cycle that follows in_last on a word char.
// Optional: define WORD_COUNT_EN to add the word_count port (terminators since reset).
module word_splitter #(
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = 5,
  parameter int UPCASE  = 1
`ifdef WORD_COUNT_EN
  ,
  parameter int COUNT_W = 16
`endif
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic       out_valid,
  output logic [7:0] out_byte,
  output logic       trunc
`ifdef WORD_COUNT_EN
  ,
  output logic [COUNT_W-1:0] word_count
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WORD  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             flag_q, flag_d;
  logic             out_valid_d;
  logic [7:0]       out_byte_d;
  logic             trunc_d;
  logic             xfer;
  logic             is_word;
  logic             at_max;
  logic [7:0]       char_mapped;

  // FLUSH owes a terminator, so no new byte can be taken that cycle.
  assign in_ready = (state_q != FLUSH);
  assign xfer     = in_valid && in_ready;
  assign at_max   = (len_q == LEN_W'(MAX_LEN));

  assign is_word = ((in_data >= 8'h41) && (in_data <= 8'h5a)) ||
                   ((in_data >= 8'h61) && (in_data <= 8'h7a)) ||
                   ((in_data >= 8'h30) && (in_data <= 8'h39)) ||
                   (in_data == 8'h27);

  // Optional lower-to-upper case folding of the forwarded character.
  always_comb begin
    char_mapped = in_data;
    if ((UPCASE != 0) && (in_data >= 8'h61) && (in_data <= 8'h7a)) begin
      char_mapped = in_data - 8'd32;
    end
  end

  // State, word length and truncation flag registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      len_q   <= '0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      flag_q  <= flag_d;
    end
  end

  // Next state: word chars open/extend a word, separators close it, FLUSH always closes.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    flag_d  = flag_q;
    if (state_q == FLUSH) begin
      state_d = IDLE;
      len_d   = '0;
      flag_d  = 1'b0;
    end else if (xfer) begin
      if (is_word) begin
        state_d = in_last ? FLUSH : WORD;
        if (at_max) begin
          flag_d = 1'b1;
        end else begin
          len_d = len_q + LEN_W'(1);
        end
      end else begin
        state_d = IDLE;
        len_d   = '0;
        flag_d  = 1'b0;
      end
    end
  end

  // Next outputs: forwarded char, terminator (with trunc) or the idle space filler.
  always_comb begin
    out_valid_d = 1'b0;
    out_byte_d  = 8'h20;
    trunc_d     = 1'b0;
    if (state_q == FLUSH) begin
      out_valid_d = 1'b1;
      out_byte_d  = 8'h00;
      trunc_d     = flag_q;
    end else if (xfer) begin
      if (is_word && !at_max) begin
        out_valid_d = 1'b1;
        out_byte_d  = char_mapped;
      end else if (!is_word && (state_q == WORD)) begin
        out_valid_d = 1'b1;
        out_byte_d  = 8'h00;
        trunc_d     = flag_q;
      end
    end
  end

  // Registered outputs so the checker sees clean, glitch-free bytes.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_byte  <= 8'h20;
      trunc     <= 1'b0;
    end else begin
      out_valid <= out_valid_d;
      out_byte  <= out_byte_d;
      trunc     <= trunc_d;
    end
  end

`ifdef WORD_COUNT_EN
  logic               term_d;
  logic [COUNT_W-1:0] word_count_q;

  // A word byte is never 8'h00, so a valid zero is always a terminator.
  assign term_d = out_valid_d && (out_byte_d == 8'h00);

  // Count terminators in step with the registered out_byte; wraps naturally.
  always_ff @(posedge clock) begin
    if (reset) begin
      word_count_q <= '0;
    end else if (term_d) begin
      word_count_q <= word_count_q + COUNT_W'(1);
    end
  end

  assign word_count = word_count_q;
`endif

endmodule

// File: tb/tb_word_splitter.sv
// Bench for word_splitter: three instances (default, MAX_LEN=4, UPCASE=0) share one input stream.
// Outputs are captured as {trunc, byte} per valid cycle and compared with word-level expectations.
module tb_word_splitter;

  typedef logic [7:0] q8_t[$];
  typedef logic [8:0] q9_t[$];

  logic       clock;
  logic       reset;
  logic       in_valid;
  logic       in_last;
  logic [7:0] in_data;
  logic       rdy[3];
  logic       ov[3];
  logic       tr[3];
  logic [7:0] ob[3];
`ifdef WORD_COUNT_EN
  logic [15:0] wc0;
  logic [15:0] wc1;
  logic [1:0]  wc2;
  int          wcq[3][$];
`endif

  int   total = 0;
  int   bad = 0;
  int   idle_err = 0;
  int   rdy_err = 0;
  int   rdy_low = 0;
  bit   mon_on = 0;
  logic [8:0] cap[3][$];
  int   maxl[3] = '{16, 4, 16};
  bit   upc[3] = '{1'b1, 1'b1, 1'b0};

  word_splitter u0 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(rdy[0]),
    .in_data(in_data), .in_last(in_last), .out_valid(ov[0]), .out_byte(ob[0]),
    .trunc(tr[0])
`ifdef WORD_COUNT_EN
    , .word_count(wc0)
`endif
  );

  word_splitter #(.MAX_LEN(4), .LEN_W(3)) u1 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(rdy[1]),
    .in_data(in_data), .in_last(in_last), .out_valid(ov[1]), .out_byte(ob[1]),
    .trunc(tr[1])
`ifdef WORD_COUNT_EN
    , .word_count(wc1)
`endif
  );

  word_splitter #(
    .UPCASE(0)
`ifdef WORD_COUNT_EN
    , .COUNT_W(2)
`endif
  ) u2 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(rdy[2]),
    .in_data(in_data), .in_last(in_last), .out_valid(ov[2]), .out_byte(ob[2]),
    .trunc(tr[2])
`ifdef WORD_COUNT_EN
    , .word_count(wc2)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Capture every valid output; note idle-cycle anomalies and ready disagreement.
  always @(negedge clock) begin
    if (mon_on) begin
      for (int i = 0; i < 3; i++) begin
        if (ov[i] === 1'b1) cap[i].push_back({tr[i], ob[i]});
        else if (ov[i] !== 1'b0 || ob[i] !== 8'h20 || tr[i] !== 1'b0) idle_err++;
      end
`ifdef WORD_COUNT_EN
      if (ov[0] === 1'b1 && ob[0] === 8'h00) wcq[0].push_back(int'(wc0));
      if (ov[1] === 1'b1 && ob[1] === 8'h00) wcq[1].push_back(int'(wc1));
      if (ov[2] === 1'b1 && ob[2] === 8'h00) wcq[2].push_back(int'(wc2));
`endif
      if (rdy[0] !== 1'b1) rdy_low++;
      if (rdy[1] !== rdy[0] || rdy[2] !== rdy[0]) rdy_err++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  function automatic bit isw(input logic [7:0] c);
    return (c >= "A" && c <= "Z") || (c >= "a" && c <= "z") || (c >= "0" && c <= "9") || c == 8'h27;
  endfunction

  function automatic logic [7:0] up_map(input logic [7:0] c, input bit up);
    if (up && c >= "a" && c <= "z") return c - 8'd32;
    return c;
  endfunction

  function automatic q8_t str2q(input string s);
    q8_t q;
    for (int k = 0; k < s.len(); k++) q.push_back(s[k]);
    return q;
  endfunction

  // Expected capture from a literal: '#' = terminator, '!' = terminator with trunc.
  function automatic q9_t mk(input string s);
    q9_t q;
    for (int k = 0; k < s.len(); k++) begin
      if (s[k] == "#") q.push_back(9'h000);
      else if (s[k] == "!") q.push_back(9'h100);
      else q.push_back({1'b0, s[k]});
    end
    return q;
  endfunction

  // Reference: split into whole words, then emit each clipped word plus its terminator.
  function automatic q9_t model(input q8_t s, input bit last, input int ml, input bit up);
    q9_t  q;
    q8_t  w;
    logic t;
    for (int k = 0; k < s.size(); k++) begin
      if (isw(s[k])) w.push_back(s[k]);
      if (!isw(s[k]) || (last && k == s.size() - 1)) begin
        if (w.size() > 0) begin
          for (int j = 0; j < w.size() && j < ml; j++) q.push_back({1'b0, up_map(w[j], up)});
          t = (w.size() > ml);
          q.push_back({t, 8'h00});
          w.delete();
        end
      end
    end
    return q;
  endfunction

  task automatic clear_caps;
    for (int i = 0; i < 3; i++) cap[i].delete();
    rdy_low = 0;
  endtask

  // Present each byte on a falling edge and hold it until in_ready allows the transfer.
  task automatic drive(input q8_t s, input bit last, input int gmax);
    int n;
    for (int k = 0; k < s.size(); k++) begin
      repeat ($urandom_range(0, gmax)) begin
        @(negedge clock);
        in_valid = 1'b0;
        in_last  = 1'b0;
      end
      @(negedge clock);
      in_valid = 1'b1;
      in_data  = s[k];
      in_last  = last && (k == s.size() - 1);
      n = 0;
      while (rdy[0] !== 1'b1 && n < 8) begin
        @(negedge clock);
        n++;
      end
      if (n >= 8) begin
        total++;
        bad++;
        $display("FAIL in_ready_timeout: in_ready=%b after %0d cycles, required 1", rdy[0], n);
      end
    end
    @(negedge clock);
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (3) @(negedge clock);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    in_valid = 1'b0;
    in_last = 1'b0;
    in_data = 8'h00;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    mon_on = 1'b1;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (ov[i] !== 1'b0 || ob[i] !== 8'h20 || tr[i] !== 1'b0 || rdy[i] !== 1'b1) begin
        bad++;
        $display("FAIL reset u%0d: valid=%b byte=%h trunc=%b ready=%b, required 0 20 0 1", i, ov[i], ob[i], tr[i], rdy[i]);
      end
    end
`ifdef WORD_COUNT_EN
    total++;
    if (wc0 !== 16'd0 || wc2 !== 2'd0) begin
      bad++;
      $display("FAIL reset_word_count: got %0d/%0d, required 0/0", wc0, wc2);
    end
`endif
  endtask

  task automatic test_qi_t;
    q9_t e[3];
    clear_caps();
    drive(str2q("Qi t"), 1'b1, 1);
    e[0] = mk("QI#T#");
    e[1] = mk("QI#T#");
    e[2] = mk("Qi#t#");
    for (int i = 0; i < 3; i++) begin
      total++;
      if (cap[i].size() != e[i].size()) begin
        bad++;
        $display("FAIL qi_t_len u%0d: got %0d bytes, required %0d", i, cap[i].size(), e[i].size());
      end else for (int k = 0; k < e[i].size(); k++) begin
        total++;
        if (cap[i][k] !== e[i][k]) begin
          bad++;
          $display("FAIL qi_t u%0d[%0d]: got %h, required %h", i, k, cap[i][k], e[i][k]);
        end
      end
    end
    total++;
    if (rdy_low !== 1) begin
      bad++;
      $display("FAIL qi_t_ready_low: got %0d cycles, required 1", rdy_low);
    end
  endtask

  task automatic test_separators;
    q9_t e[3];
    clear_caps();
    drive(str2q("  ,,quack!!  "), 1'b0, 2);
    e[0] = mk("QUACK#");
    e[1] = mk("QUAC!");
    e[2] = mk("quack#");
    for (int i = 0; i < 3; i++) begin
      total++;
      if (cap[i].size() != e[i].size()) begin
        bad++;
        $display("FAIL quack_len u%0d: got %0d bytes, required %0d", i, cap[i].size(), e[i].size());
      end else for (int k = 0; k < e[i].size(); k++) begin
        total++;
        if (cap[i][k] !== e[i][k]) begin
          bad++;
          $display("FAIL quack u%0d[%0d]: got %h, required %h", i, k, cap[i][k], e[i][k]);
        end
      end
    end
    total++;
    if (rdy_low !== 0) begin
      bad++;
      $display("FAIL quack_ready_low: got %0d cycles, required 0", rdy_low);
    end
  endtask

  task automatic test_case_and_trunc;
    q9_t e[3];
    clear_caps();
    drive(str2q("aB QUEUES "), 1'b0, 0);
    e[0] = mk("AB#QUEUES#");
    e[1] = mk("AB#QUEU!");
    e[2] = mk("aB#QUEUES#");
    for (int i = 0; i < 3; i++) begin
      total++;
      if (cap[i].size() != e[i].size()) begin
        bad++;
        $display("FAIL case_trunc_len u%0d: got %0d bytes, required %0d", i, cap[i].size(), e[i].size());
      end else for (int k = 0; k < e[i].size(); k++) begin
        total++;
        if (cap[i][k] !== e[i][k]) begin
          bad++;
          $display("FAIL case_trunc u%0d[%0d]: got %h, required %h", i, k, cap[i][k], e[i][k]);
        end
      end
    end
  endtask

  task automatic test_reset_midword;
    q9_t e[3];
    clear_caps();
    drive(str2q("QU"), 1'b0, 0);
    // Reset arrives together with a transfer of a word char with in_last.
    reset = 1'b1;
    in_valid = 1'b1;
    in_data = "X";
    in_last = 1'b1;
    @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (ov[i] !== 1'b0 || ob[i] !== 8'h20 || tr[i] !== 1'b0 || rdy[i] !== 1'b1) begin
        bad++;
        $display("FAIL midword_reset u%0d: valid=%b byte=%h trunc=%b ready=%b, required 0 20 0 1", i, ov[i], ob[i], tr[i], rdy[i]);
      end
    end
`ifdef WORD_COUNT_EN
    for (int i = 0; i < 3; i++) wcq[i].delete();
`endif
    reset = 1'b0;
    in_valid = 1'b0;
    in_last = 1'b0;
    drive(str2q(" "), 1'b0, 0);
    e[0] = mk("QU");
    e[1] = mk("QU");
    e[2] = mk("QU");
    for (int i = 0; i < 3; i++) begin
      total++;
      if (cap[i].size() != e[i].size()) begin
        bad++;
        $display("FAIL midword_len u%0d: got %0d bytes, required %0d", i, cap[i].size(), e[i].size());
      end else for (int k = 0; k < e[i].size(); k++) begin
        total++;
        if (cap[i][k] !== e[i][k]) begin
          bad++;
          $display("FAIL midword u%0d[%0d]: got %h, required %h", i, k, cap[i][k], e[i][k]);
        end
      end
    end
  endtask

  task automatic test_random;
    logic [7:0] seps[6] = '{8'h20, 8'h2c, 8'h00, 8'h21, 8'hff, 8'h0a};
    logic [7:0] wch[6]  = '{"a", "Z", "m", "Q", "7", 8'h27};
    q8_t s;
    q9_t e;
    int  len;
    int  pct;
    for (int it = 0; it < 25; it++) begin
      s.delete();
      len = $urandom_range(1, 40);
      pct = (it % 3 == 0) ? 95 : 65;
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 99) < pct) begin
          if ($urandom_range(0, 1) == 0) s.push_back(wch[$urandom_range(0, 5)]);
          else s.push_back(8'($urandom_range(8'h61, 8'h7a)));
        end else begin
          s.push_back(seps[$urandom_range(0, 5)]);
        end
      end
      clear_caps();
      drive(s, 1'b1, it % 3);
      for (int i = 0; i < 3; i++) begin
        e = model(s, 1'b1, maxl[i], upc[i]);
        total++;
        if (cap[i].size() != e.size()) begin
          bad++;
          $display("FAIL random_len it%0d u%0d: got %0d bytes, required %0d", it, i, cap[i].size(), e.size());
        end else for (int k = 0; k < e.size(); k++) begin
          total++;
          if (cap[i][k] !== e[k]) begin
            bad++;
            $display("FAIL random it%0d u%0d[%0d]: got %h, required %h", it, i, k, cap[i][k], e[k]);
          end
        end
      end
      total++;
      if (rdy_low !== int'(isw(s[s.size() - 1]))) begin
        bad++;
        $display("FAIL random_ready_low it%0d: got %0d cycles, required %0d", it, rdy_low, int'(isw(s[s.size() - 1])));
      end
    end
    total++;
    if (idle_err !== 0 || rdy_err !== 0) begin
      bad++;
      $display("FAIL idle_outputs: idle_err=%0d ready_err=%0d, required 0 0", idle_err, rdy_err);
    end
  endtask

`ifdef WORD_COUNT_EN
  task automatic test_word_count;
    int e2[5] = '{1, 2, 3, 0, 1};
    for (int i = 0; i < 3; i++) wcq[i].delete();
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    clear_caps();
    drive(str2q("a b c d e "), 1'b0, 0);
    total++;
    if (wcq[2].size() != 5 || wcq[0].size() != 5) begin
      bad++;
      $display("FAIL word_count_len: got %0d/%0d terminators, required 5/5", wcq[0].size(), wcq[2].size());
    end else for (int k = 0; k < 5; k++) begin
      total++;
      if (wcq[2][k] !== e2[k] || wcq[0][k] !== k + 1) begin
        bad++;
        $display("FAIL word_count[%0d]: got %0d/%0d, required %0d/%0d", k, wcq[0][k], wcq[2][k], k + 1, e2[k]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_qi_t();
    test_separators();
    test_case_and_trunc();
    test_reset_midword();
    test_random();
`ifdef WORD_COUNT_EN
    test_word_count();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
